// File: rtl/dvi_pattern_gen.sv
// Bring-up raster source: colour bars, solid, checkerboard or gradient on a ready/valid pixel stream.
// Define PATTERN_SCROLL_EN to scroll the colour bars left by one pixel per completed frame.
module dvi_pattern_gen #(
  parameter int unsigned WIDTH  = 800,
  parameter int unsigned HEIGHT = 600,
  parameter int unsigned BAR_W  = 100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [1:0]  mode,
  input  logic [23:0] solid_color,
  output logic [23:0] video,
  output logic        video_valid,
  input  logic        video_ready,
  output logic        frame_done,
  output logic [15:0] frame_count
);

  localparam int unsigned XW = $clog2(WIDTH);
  localparam int unsigned YW = $clog2(HEIGHT);

  typedef enum logic {S_IDLE, S_ACTIVE} state_t;

  state_t        r_state, w_state;
  logic [XW-1:0] r_x, w_x;
  logic [YW-1:0] r_y, w_y;
  logic [1:0]    r_mode_q, w_mode_q;
  logic [23:0]   r_color_q, w_color_q;
  logic [23:0]   r_video, w_video;
  logic          r_valid, w_valid;
  logic          r_frame_done, w_frame_done;
  logic [15:0]   r_frame_count, w_frame_count;
  logic [15:0]   w_off_now, w_off_next;
  logic          w_accept, w_eol, w_last;

  // Pixel value for (px, py); poff rotates the bar pattern horizontally.
  function automatic logic [23:0] f_pixel(input logic [15:0] px, input logic [7:0] py,
                                          input logic [1:0] pm, input logic [23:0] pc,
                                          input logic [7:0] pfc, input logic [15:0] poff);
    logic [16:0] xs;
    logic [16:0] idx;
    logic [23:0] pix;
    xs = 17'(px) + 17'(poff);
    if (xs >= 17'(WIDTH)) xs = xs - 17'(WIDTH);
    idx = xs / 17'(BAR_W);
    pix = 24'h000000;
    case (pm)
      2'd0: begin
        case (idx)
          17'd0:   pix = 24'hFFFFFF;
          17'd1:   pix = 24'hFFFF00;
          17'd2:   pix = 24'h00FFFF;
          17'd3:   pix = 24'h00FF00;
          17'd4:   pix = 24'hFF00FF;
          17'd5:   pix = 24'hFF0000;
          17'd6:   pix = 24'h0000FF;
          default: pix = 24'h000000;
        endcase
      end
      2'd1:    pix = pc;
      2'd2:    pix = (px[5] ^ py[5]) ? 24'hFFFFFF : 24'h000000;
      default: pix = {px[7:0], py, pfc};
    endcase
    return pix;
  endfunction

  assign w_accept = r_valid & video_ready;
  assign w_eol    = (r_x == XW'(WIDTH - 1));
  assign w_last   = w_accept & w_eol & (r_y == YW'(HEIGHT - 1));

`ifdef PATTERN_SCROLL_EN
  logic [XW-1:0] r_offset, w_offset;

  assign w_offset   = w_last ? ((r_offset == XW'(WIDTH - 1)) ? '0 : r_offset + XW'(1)) : r_offset;
  assign w_off_now  = 16'(r_offset);
  assign w_off_next = 16'(w_offset);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_offset <= '0;
    else        r_offset <= w_offset;
  end
`else
  assign w_off_now  = 16'd0;
  assign w_off_next = 16'd0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state;
  end

  always_comb begin
    w_state = r_state;
    case (r_state)
      S_IDLE:  if (enable) w_state = S_ACTIVE;
      default: if (w_last && !enable) w_state = S_IDLE;
    endcase
  end

  // Next raster position and pixel; a frame boundary relatches the configuration.
  always_comb begin
    w_x           = r_x;
    w_y           = r_y;
    w_mode_q      = r_mode_q;
    w_color_q     = r_color_q;
    w_video       = r_video;
    w_valid       = r_valid;
    w_frame_done  = 1'b0;
    w_frame_count = r_frame_count;
    case (r_state)
      S_IDLE: begin
        w_valid = 1'b0;
        if (enable) begin
          w_mode_q  = mode;
          w_color_q = solid_color;
          w_x       = '0;
          w_y       = '0;
          w_video   = f_pixel(16'd0, 8'd0, mode, solid_color, r_frame_count[7:0], w_off_now);
          w_valid   = 1'b1;
        end
      end
      default: begin
        if (w_accept) begin
          if (w_last) begin
            w_frame_done  = 1'b1;
            w_frame_count = r_frame_count + 16'd1;
            w_x           = '0;
            w_y           = '0;
            if (enable) begin
              w_mode_q  = mode;
              w_color_q = solid_color;
              w_video   = f_pixel(16'd0, 8'd0, mode, solid_color, w_frame_count[7:0], w_off_next);
            end else begin
              w_valid = 1'b0;
            end
          end else begin
            w_x     = w_eol ? '0 : r_x + XW'(1);
            w_y     = w_eol ? r_y + YW'(1) : r_y;
            w_video = f_pixel(16'(w_x), 8'(w_y), r_mode_q, r_color_q, r_frame_count[7:0], w_off_now);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x           <= '0;
      r_y           <= '0;
      r_mode_q      <= '0;
      r_color_q     <= '0;
      r_video       <= '0;
      r_valid       <= 1'b0;
      r_frame_done  <= 1'b0;
      r_frame_count <= '0;
    end else begin
      r_x           <= w_x;
      r_y           <= w_y;
      r_mode_q      <= w_mode_q;
      r_color_q     <= w_color_q;
      r_video       <= w_video;
      r_valid       <= w_valid;
      r_frame_done  <= w_frame_done;
      r_frame_count <= w_frame_count;
    end
  end

  assign video       = r_video;
  assign video_valid = r_valid;
  assign frame_done  = r_frame_done;
  assign frame_count = r_frame_count;

endmodule

// File: tb/tb_dvi_pattern_gen.sv
// Self-checking bench for dvi_pattern_gen on a reduced raster; expected frames are queued and
// compared pixel by pixel as the generator's output is accepted.
module tb_dvi_pattern_gen;

  localparam int W    = 40;
  localparam int H    = 34;
  localparam int BW   = 4;
  localparam int NPIX = W * H;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic [1:0]  mode;
  logic [23:0] solid_color;
  logic [23:0] video;
  logic        video_valid;
  logic        video_ready;
  logic        frame_done;
  logic [15:0] frame_count;

  int          checks;
  int          errors;
  logic [15:0] m_fc;
  int          m_off;
  logic [23:0] exp_q[$];

  dvi_pattern_gen #(.WIDTH(W), .HEIGHT(H), .BAR_W(BW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .mode        (mode),
    .solid_color (solid_color),
    .video       (video),
    .video_valid (video_valid),
    .video_ready (video_ready),
    .frame_done  (frame_done),
    .frame_count (frame_count)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] bar_colour(input int b);
    case (b)
      0:       return 24'hFFFFFF;
      1:       return 24'hFFFF00;
      2:       return 24'h00FFFF;
      3:       return 24'h00FF00;
      4:       return 24'hFF00FF;
      5:       return 24'hFF0000;
      6:       return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

  function automatic logic [23:0] model_pix(input int x, input int y, input int md,
                                            input logic [23:0] col, input logic [15:0] fc,
                                            input int off);
    int b;
    b = ((x + off) % W) / BW;
    if (b > 7) b = 7;
    case (md)
      0:       return bar_colour(b);
      1:       return col;
      2:       return ((((x >> 5) & 1) ^ ((y >> 5) & 1)) != 0) ? 24'hFFFFFF : 24'h000000;
      default: return {8'(x), 8'(y), fc[7:0]};
    endcase
  endfunction

  task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic push_frame(input int md, input logic [23:0] col);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        exp_q.push_back(model_pix(x, y, md, col, m_fc, m_off));
  endtask

  // Drive ready at pct% until the queued frame drains; at acceptance count chg_at apply new inputs.
  task automatic run_frame(input int pct, input int chg_at, input logic [1:0] cmode,
                           input logic [23:0] ccol, input logic cen, input logic exp_valid_after);
    int          acc;
    int          cyc;
    logic        stall;
    logic        r;
    logic [23:0] pv;
    logic [23:0] e;
    acc   = 0;
    cyc   = 0;
    stall = 1'b0;
    pv    = '0;
    while (exp_q.size() > 0 && cyc < 20 * NPIX) begin
      @(negedge clk);
      cyc++;
      chk("frame_done_mid", 24'(frame_done), 24'd0);
      if (stall) begin
        chk("hold_video", video, pv);
        chk("hold_valid", 24'(video_valid), 24'd1);
      end
      r = ($urandom_range(99) < 32'(pct));
      video_ready = r;
      if (video_valid && r) begin
        e = exp_q.pop_front();
        chk("pixel", video, e);
        acc++;
        if (acc == chg_at) begin
          mode        = cmode;
          solid_color = ccol;
          enable      = cen;
        end
      end
      stall = video_valid && !r;
      pv    = video;
    end
    if (exp_q.size() > 0) begin
      chk("frame_timeout", 24'(exp_q.size()), 24'd0);
      exp_q.delete();
    end
    m_fc = m_fc + 16'd1;
`ifdef PATTERN_SCROLL_EN
    m_off = (m_off + 1) % W;
`endif
    @(negedge clk);
    video_ready = 1'b0;
    chk("frame_done_pulse", 24'(frame_done), 24'd1);
    chk("frame_count", 24'(frame_count), 24'(m_fc));
    chk("valid_after_frame", 24'(video_valid), 24'(exp_valid_after));
  endtask

  initial begin
    clk         = 1'b0;
    checks      = 0;
    errors      = 0;
    m_fc        = 16'd0;
    m_off       = 0;
    rst_n       = 1'b0;
    enable      = 1'b1;
    mode        = 2'd0;
    solid_color = 24'h000000;
    video_ready = 1'b1;

    // Reset holds everything clear even with enable and ready high
    repeat (3) @(negedge clk);
    chk("reset_video", video, 24'h000000);
    chk("reset_valid", 24'(video_valid), 24'd0);
    chk("reset_frame_count", 24'(frame_count), 24'd0);
    chk("reset_frame_done", 24'(frame_done), 24'd0);
    video_ready = 1'b0;
    rst_n       = 1'b1;
    push_frame(0, 24'h0);
    @(negedge clk);
    chk("first_valid", 24'(video_valid), 24'd1);
    chk("first_pixel", video, 24'hFFFFFF);

    // Full-rate bars, then the same bars under random backpressure
    run_frame(100, -1, 2'd0, 24'h0, 1'b1, 1'b1);
    push_frame(0, 24'h0);
    run_frame(50, -1, 2'd0, 24'h0, 1'b1, 1'b1);

    // Mode change mid-frame only takes effect at the next frame, with no bubble
    push_frame(0, 24'h0);
    run_frame(100, 1000, 2'd1, 24'h123456, 1'b1, 1'b1);
    push_frame(1, 24'h123456);
    run_frame(60, 500, 2'd2, 24'h123456, 1'b0, 1'b0);

    // Idle: ready is ignored while nothing is valid
    video_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("idle_valid", 24'(video_valid), 24'd0);
      chk("idle_frame_count", 24'(frame_count), 24'(m_fc));
    end
    video_ready = 1'b0;
    enable      = 1'b1;
    push_frame(2, 24'h123456);
    @(negedge clk);
    chk("restart_valid", 24'(video_valid), 24'd1);
    run_frame(50, 700, 2'd3, 24'h0, 1'b1, 1'b1);

    // Gradient carries the frame count captured at frame start
    push_frame(3, 24'h0);
    run_frame(100, 10, 2'd0, 24'h0, 1'b1, 1'b1);

    push_frame(0, 24'h0);
    run_frame(100, -1, 2'd0, 24'h0, 1'b1, 1'b1);
`ifdef PATTERN_SCROLL_EN
    // Keep running bars until the scroll offset has wrapped through zero and moved on again
    for (int f = 0; f < W; f++) begin
      push_frame(0, 24'h0);
      run_frame(100, -1, 2'd0, 24'h0, 1'b1, 1'b1);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dvi_pattern_gen.md
# dvi_pattern_gen

- Bring-up video source that produces a continuous raster of 24-bit RGB pixels on the same ready/valid interface the DVI block consumes.
- Sits directly upstream of DVI, in place of the Memory150 video path, so the display path can be validated without the CPU or DDR2.
- Provides four selectable patterns: colour bars, solid colour, checkerboard and gradient.
- Reports frame completion and keeps a running frame count.

## Interface

Parameters:
- WIDTH, 800: active pixels per line.
- HEIGHT, 600: active lines per frame.
- BAR_W, 100: colour-bar width in pixels.

Ports:
- clk  in  1: pixel/cpu clock, rising-edge.
- rst_n  in  1: reset. Asynchronous assertion, active-low; all state clears while low.
- enable  in  1: run request, sampled only at frame boundaries.
- mode  in  2: 0 colour bars, 1 solid, 2 checkerboard, 3 gradient. Sampled only at frame boundaries.
- solid_color  in  24: RGB used in mode 1, sampled with mode.
- video  out  24: pixel {R,G,B}.
- video_valid  out  1: pixel on `video` is valid.
- video_ready  in  1: consumer accepts the pixel this cycle.
- frame_done  out  1: one-cycle pulse on acceptance of the last pixel of a frame.
- frame_count  out  16: completed frames; wraps 0xFFFF→0.

## Operation

State machine has two states, IDLE and ACTIVE.

IDLE:
- video_valid=0.
- If enable=1 at a clock edge:
  - latch mode and solid_color into `mode_q` and `color_q`;
  - set x=0, y=0;
  - load `video` with pixel(0,0);
  - set video_valid=1;
  - go to ACTIVE.

ACTIVE:
- A pixel is accepted when video_valid & video_ready.
- On acceptance:
  - x increments;
  - at x=WIDTH-1, x wraps to 0 and y increments;
  - `video` loads the next pixel.
- Without acceptance, video and video_valid hold stable. The pixel is never changed or withdrawn.
- On acceptance at (WIDTH-1, HEIGHT-1):
  - frame_done=1 for one cycle;
  - frame_count increments;
  - y wraps to 0;
  - if enable=1: relatch mode and color, present pixel(0,0) of the new frame next cycle, no bubble;
  - else: video_valid=0 and return to IDLE.
- mode, solid_color and enable changes mid-frame have no effect until the frame boundary.

Pixel functions (x, y unsigned, sized to hold WIDTH-1 and HEIGHT-1):
- Bars: index = min(xs / BAR_W, 7), where xs = x by default.
  - Colours by index: FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000.
- Solid: color_q.
- Checkerboard: (x[5] ^ y[5]) ? FFFFFF : 000000.
- Gradient: {x[7:0], y[7:0], frame_count[7:0]}.
  - frame_count is the value at frame start, constant for the whole frame.

## Timing

- Reset values:
  - video=0, video_valid=0, frame_done=0, frame_count=0;
  - x=0, y=0, state=IDLE;
  - mode_q=0, color_q=0, scroll offset=0.
- Latency: enable high at edge N (IDLE) gives video_valid=1 with pixel(0,0) after edge N.
- Throughput: one pixel per cycle while video_ready=1.
- frame_done is registered and high in the cycle after the final acceptance edge.
- Reset mid-frame: outputs clear immediately. After release, the generator restarts from IDLE at pixel(0,0).
- video_ready while video_valid=0 is ignored.

## Configuration

Macro PATTERN_SCROLL_EN:
- Defined:
  - A scroll offset register (0..WIDTH-1) increments once per completed frame and wraps WIDTH-1→0.
  - In bar mode, xs = x + offset, minus WIDTH if the sum is ≥ WIDTH.
  - Bars move left by one pixel per frame.
- Undefined: offset logic is absent, xs = x, and bars are static.
- Other modes are identical either way.

## Test plan

1. **Reset:** rst_n=0 with enable=1 → video=0, valid=0, frame_count=0. Release → pixel(0,0)=FFFFFF valid one edge later (mode 0).
2. **Bars, full-rate frame:** ready held 1 → 480000 accepted pixels.
   - Pixels at x=99 and x=100 read FFFFFF then FFFF00; x=799 reads 000000.
   - Exactly one frame_done pulse; frame_count=1.
3. **Backpressure:** ready toggles randomly 50% → video stable whenever valid & !ready. Accepted sequence matches the full-rate sequence exactly.
4. **Mid-frame mode change:** switch mode 0→1 (solid_color=123456) at pixel 1000 → rest of frame stays bars. Next frame's pixel(0,0)=123456 with no idle cycle.
5. **Enable drop:** enable=0 mid-frame → frame completes. valid=0 after final acceptance. Mode 2 pixel(32,0)=FFFFFF and (32,32)=000000 on the next run.
6. **PATTERN_SCROLL_EN:** after 1 frame, pixel(99,0)=FFFF00. After 800 frames the offset wraps and pixel(99,0)=FFFFFF again.
